row_normalize_seq: RTL and testbench

- Final-normalisation sequencer for the FlashAttention output path: O_i = O_acc_i / l for one output row.
- Accepts one accumulated output row (VEC_LEN numerators) plus its row-sum l, all DIV_INPUT_QT.
- Streams (O_acc_i, l) pairs in index order into int_division over that block's valid/ready handshake, collects the quotients and presents the normalised row as one OUTPUT_VEC_QT vector to the writeback stage.

---
 rtl/row_normalize_seq_pkg.sv | 31 +++
 rtl/row_normalize_seq.sv | 189 ++++++++++++++++++
 tb/tb_row_normalize_seq.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/row_normalize_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : row_normalize_seq_pkg
// Description : Shared types for the FlashAttention output-row normaliser.
//               DIV_INPUT_QT  : signed Q8.8 divider operand (numerator / l).
//               OUTPUT_VEC_QT : signed Q0.7 divider quotient.
//               NORM_ROW_IN_T / NORM_ROW_OUT_T : one full row at the default
//               head dimension.
//               ROW_NORM_STATE_T : row_normalize_seq sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package row_normalize_seq_pkg;

    localparam int DIV_IN_W         = 16;  // Q8.8
    localparam int OUT_W            = 8;   // Q0.7
    localparam int ROW_NORM_VEC_LEN = 16;

    typedef logic signed [DIV_IN_W-1:0] DIV_INPUT_QT;
    typedef logic signed [OUT_W-1:0]    OUTPUT_VEC_QT;

    typedef DIV_INPUT_QT  [ROW_NORM_VEC_LEN-1:0] NORM_ROW_IN_T;
    typedef OUTPUT_VEC_QT [ROW_NORM_VEC_LEN-1:0] NORM_ROW_OUT_T;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ROW_NORM_STATE_T;

endpackage
`default_nettype wire

// File: rtl/row_normalize_seq.sv
`default_nettype none
// ============================================================================
// Module      : row_normalize_seq
// Description : Final-normalisation sequencer, O_i = O_acc_i / l for one row.
//               Captures a row of VEC_LEN numerators plus the row-sum l,
//               streams (O_acc_i, l) pairs in index order to an external
//               int_division block, collects the quotients in issue order and
//               presents the whole normalised row to writeback.
//
// Optional    : ROW_NORM_ZERO_BYPASS_EN - when defined, a captured row-sum of
//               zero skips the divider and produces an all-zero row.
//
// Ports       : clock, reset        - single clock, synchronous active-high reset
//               vld_in / rdy_out    - upstream row handshake
//               row_in, rowsum_in   - numerators and denominator (Q8.8)
//               vld_out / rdy_in    - downstream row handshake
//               vec_out             - normalised row (Q0.7)
//               div_vld_o/div_rdy_i - issue handshake to the divider
//               div_num_o/div_den_o - divider operands
//               div_vld_i/div_rdy_o - result handshake from the divider
//               div_quot_i          - divider quotient
// Revision    : 1.0 - initial release
// ============================================================================
module row_normalize_seq
    import row_normalize_seq_pkg::*;
#(
    parameter int VEC_LEN = 16,
    parameter int CNT_W   = $clog2(VEC_LEN + 1)
) (
    input  logic                             clock,
    input  logic                             reset,

    input  logic                             vld_in,
    output logic                             rdy_out,
    input  logic [VEC_LEN-1:0][DIV_IN_W-1:0] row_in,
    input  logic [DIV_IN_W-1:0]              rowsum_in,

    output logic                             vld_out,
    input  logic                             rdy_in,
    output logic [VEC_LEN-1:0][OUT_W-1:0]    vec_out,

    output logic                             div_vld_o,
    input  logic                             div_rdy_i,
    output logic [DIV_IN_W-1:0]              div_num_o,
    output logic [DIV_IN_W-1:0]              div_den_o,
    input  logic                             div_vld_i,
    output logic                             div_rdy_o,
    input  logic [OUT_W-1:0]                 div_quot_i
);

    localparam int               IDX_W     = $clog2(VEC_LEN);
    localparam logic [CNT_W-1:0] c_vec_len = CNT_W'(VEC_LEN);
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(VEC_LEN - 1);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    ROW_NORM_STATE_T                  r_state;
    ROW_NORM_STATE_T                  w_state_nxt;

    logic [VEC_LEN-1:0][DIV_IN_W-1:0] r_row;
    logic [DIV_IN_W-1:0]              r_den;
    logic [CNT_W-1:0]                 r_iss_cnt;
    logic [CNT_W-1:0]                 r_col_cnt;
    logic [VEC_LEN-1:0][OUT_W-1:0]    r_vec;

    logic                             w_accept;
    logic                             w_iss_fire;
    logic                             w_col_fire;
    logic                             w_zero_bypass;
    logic [IDX_W-1:0]                 w_iss_idx;
    logic [IDX_W-1:0]                 w_col_idx;

    // Counters are one bit wider than an index so they can reach VEC_LEN;
    // the low bits address the row/vector slots while the count is in range.
    assign w_iss_idx  = r_iss_cnt[IDX_W-1:0];
    assign w_col_idx  = r_col_cnt[IDX_W-1:0];

    assign w_accept   = vld_in && rdy_out;
    assign w_iss_fire = div_vld_o && div_rdy_i;
    assign w_col_fire = div_vld_i && div_rdy_o;

`ifdef ROW_NORM_ZERO_BYPASS_EN
    // A zero row-sum means an empty softmax row; emit zeros without
    // involving the divider.
    assign w_zero_bypass = (rowsum_in == '0);
`else
    // Zero row-sum goes through the divider and picks up its saturation.
    assign w_zero_bypass = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        rdy_out     = 1'b0;
        vld_out     = 1'b0;
        div_vld_o   = 1'b0;
        div_rdy_o   = 1'b0;
        div_num_o   = '0;
        div_den_o   = '0;

        case (r_state)
            IDLE: begin
                rdy_out = 1'b1;
                if (vld_in) begin
                    w_state_nxt = BUSY;
                end
            end

            BUSY: begin
                // Issue and collect sides advance independently, so the
                // divider may hold several elements in flight.
                div_vld_o = (r_iss_cnt < c_vec_len);
                div_rdy_o = (r_col_cnt < c_vec_len);
                if (r_iss_cnt < c_vec_len) begin
                    div_num_o = r_row[w_iss_idx];
                    div_den_o = r_den;
                end
                // Second term covers a bypassed row whose counters were
                // preloaded to VEC_LEN at capture.
                if ((div_vld_i && (r_col_cnt < c_vec_len) && (r_col_cnt == c_last)) ||
                    (r_col_cnt == c_vec_len)) begin
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                vld_out = 1'b1;
                if (rdy_in) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture, counters and collect register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_row     <= '0;
            r_den     <= '0;
            r_iss_cnt <= '0;
            r_col_cnt <= '0;
            r_vec     <= '0;
        end else if (w_accept) begin
            r_row <= row_in;
            r_den <= rowsum_in;
            r_vec <= '0;
            if (w_zero_bypass) begin
                r_iss_cnt <= c_vec_len;
                r_col_cnt <= c_vec_len;
            end else begin
                r_iss_cnt <= '0;
                r_col_cnt <= '0;
            end
        end else begin
            if (w_iss_fire) begin
                r_iss_cnt <= r_iss_cnt + c_one;
            end
            // Results arrive in issue order, so the collect count is also
            // the destination slot.
            if (w_col_fire) begin
                r_vec[w_col_idx] <= div_quot_i;
                r_col_cnt        <= r_col_cnt + c_one;
            end
        end
    end

    // vec_out only changes while BUSY, so it is stable throughout DONE.
    assign vec_out = r_vec;

endmodule
`default_nettype wire

// File: tb/tb_row_normalize_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_row_normalize_seq
// Description : Self-checking bench for row_normalize_seq. Contains a
//               behavioural int_division model (in-order, random latency,
//               random input stalls) and a row-level reference that computes
//               each slot as saturate(num * 128 / l).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_row_normalize_seq;

    localparam int VL  = 16;
    localparam int DW  = 16;
    localparam int OW  = 8;

    typedef logic [VL-1:0][DW-1:0] row_t;
    typedef logic [VL-1:0][OW-1:0] vec_t;

    typedef struct {
        logic [OW-1:0] q;
        int            due;
    } pend_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          vld_in = 1'b0;
    logic          rdy_out;
    row_t          row_in = '0;
    logic [DW-1:0] rowsum_in = '0;
    logic          vld_out;
    logic          rdy_in = 1'b0;
    vec_t          vec_out;
    logic          div_vld_o;
    logic          div_rdy_i = 1'b0;
    logic [DW-1:0] div_num_o;
    logic [DW-1:0] div_den_o;
    logic          div_vld_i = 1'b0;
    logic          div_rdy_o;
    logic [OW-1:0] div_quot_i = '0;

    int n_checks = 0;
    int n_errors = 0;

    // divider model state
    int      lat_max   = 1;
    int      stall_pct = 0;
    int      cyc       = 0;
    int      iss_count = 0;
    pend_t   pend[$];
    logic    s_iss = 1'b0;
    logic    s_col = 1'b0;
    logic    s_rst = 1'b1;
    logic [DW-1:0] s_num = '0;
    logic [DW-1:0] s_den = '0;

    row_normalize_seq #(.VEC_LEN(VL)) dut (
        .clock      (clock),
        .reset      (reset),
        .vld_in     (vld_in),
        .rdy_out    (rdy_out),
        .row_in     (row_in),
        .rowsum_in  (rowsum_in),
        .vld_out    (vld_out),
        .rdy_in     (rdy_in),
        .vec_out    (vec_out),
        .div_vld_o  (div_vld_o),
        .div_rdy_i  (div_rdy_i),
        .div_num_o  (div_num_o),
        .div_den_o  (div_den_o),
        .div_vld_i  (div_vld_i),
        .div_rdy_o  (div_rdy_o),
        .div_quot_i (div_quot_i)
    );

    always #5 clock = ~clock;

    // Q8.8 / Q8.8 -> Q0.7, truncating toward zero and saturating.
    function automatic logic [OW-1:0] ref_div(input logic signed [DW-1:0] n,
                                              input logic signed [DW-1:0] d);
        int q;
        if (d == 0) begin
            return (n >= 0) ? 8'h7F : 8'h80;
        end
        q = (int'(n) * 128) / int'(d);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q[OW-1:0];
    endfunction

    function automatic vec_t model_row(input row_t r, input logic [DW-1:0] d);
        vec_t v;
`ifdef ROW_NORM_ZERO_BYPASS_EN
        if (d == '0) return '0;
`endif
        for (int i = 0; i < VL; i++) begin
            v[i] = ref_div(r[i], d);
        end
        return v;
    endfunction

    function automatic row_t rand_row();
        row_t r;
        for (int i = 0; i < VL; i++) begin
            r[i] = DW'($urandom_range(1023) - 512);
        end
        return r;
    endfunction

    // Handshakes are sampled mid-cycle, i.e. the values the next edge sees.
    always @(negedge clock) begin
        s_rst = reset;
        s_iss = div_vld_o && div_rdy_i && !reset;
        s_col = div_vld_i && div_rdy_o && !reset;
        s_num = div_num_o;
        s_den = div_den_o;
        if (s_iss) iss_count++;
    end

    always @(posedge clock) begin
        #1;
        cyc++;
        if (s_rst) begin
            pend.delete();
        end else begin
            if (s_col && pend.size() > 0) void'(pend.pop_front());
            if (s_iss) begin
                pend_t p;
                p.q   = ref_div(s_num, s_den);
                p.due = cyc + $urandom_range(lat_max, 1) - 1;
                pend.push_back(p);
            end
        end
        div_rdy_i = ($urandom_range(99) >= stall_pct);
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            div_vld_i  = 1'b1;
            div_quot_i = pend[0].q;
        end else begin
            div_vld_i  = 1'b0;
            div_quot_i = '0;
        end
    end

    // ------------------------------------------------------------------
    // Helpers (timing: called and return at 1 time unit after an edge)
    // ------------------------------------------------------------------
    task automatic push_row(input row_t r, input logic [DW-1:0] d);
        int n = 0;
        row_in    = r;
        rowsum_in = d;
        vld_in    = 1'b1;
        while (!rdy_out && n < 500) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        vld_in = 1'b0;
    endtask

    task automatic wait_valid(output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (vld_out) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
            edges++;
        end
    endtask

    task automatic release_row();
        rdy_in = 1'b1;
        @(posedge clock); #1;
        rdy_in = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset  = 1'b1;
        vld_in = 1'b0;
        rdy_in = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (rdy_out !== 1'b1 || vld_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hs: rdy_out=%b vld_out=%b required 1 0", rdy_out, vld_out);
        end
        n_checks++;
        if (div_vld_o !== 1'b0 || div_rdy_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_div_hs: div_vld_o=%b div_rdy_o=%b required 0 0", div_vld_o, div_rdy_o);
        end
        n_checks++;
        if (vec_out !== '0 || div_num_o !== '0 || div_den_o !== '0) begin
            n_errors++;
            $display("FAIL reset_data: vec=%h num=%h den=%h required all zero", vec_out, div_num_o, div_den_o);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_unit_row();
        row_t r;
        vec_t e;
        int   edges, base;
        bit   seen;
        lat_max = 1; stall_pct = 0;
        for (int i = 0; i < VL; i++) begin
            r[i] = 16'h0100;   // 1.0
            e[i] = 8'd32;      // 0.25
        end
        base = iss_count;
        push_row(r, 16'h0400);  // l = 4.0
        wait_valid(edges, seen);
        n_checks++;
        if (!seen || edges + 1 != VL + 2) begin
            n_errors++;
            $display("FAIL unit_latency: seen=%0d cycles=%0d required 1 %0d", seen, edges + 1, VL + 2);
        end
        n_checks++;
        if (vec_out !== e) begin
            n_errors++;
            $display("FAIL unit_row: got %h required %h", vec_out, e);
        end
        n_checks++;
        if (iss_count - base != VL) begin
            n_errors++;
            $display("FAIL unit_issues: got %0d required %0d", iss_count - base, VL);
        end
        release_row();
        n_checks++;
        if (vld_out !== 1'b0 || rdy_out !== 1'b1) begin
            n_errors++;
            $display("FAIL unit_once: vld_out=%b rdy_out=%b required 0 1", vld_out, rdy_out);
        end
    endtask

    task automatic test_mixed_signs();
        row_t r;
        vec_t e;
        int   edges;
        bit   seen;
        lat_max = 1; stall_pct = 0;
        r    = rand_row();
        r[0] = 16'h0080;   //  0.5
        r[1] = 16'hFF80;   // -0.5
        r[2] = 16'h0000;   //  0
        r[3] = 16'h00C0;   //  0.75
        e    = model_row(r, 16'h0100);
        push_row(r, 16'h0100);
        wait_valid(edges, seen);
        n_checks++;
        if (!seen || vec_out[0] !== 8'd64 || vec_out[1] !== 8'hC0 ||
            vec_out[2] !== 8'd0 || vec_out[3] !== 8'd96) begin
            n_errors++;
            $display("FAIL mixed_head: seen=%0d got %h %h %h %h required 40 c0 00 60",
                     seen, vec_out[0], vec_out[1], vec_out[2], vec_out[3]);
        end
        n_checks++;
        if (vec_out !== e) begin
            n_errors++;
            $display("FAIL mixed_row: got %h required %h", vec_out, e);
        end
        release_row();
    endtask

    task automatic test_random_latency();
        row_t r;
        vec_t e;
        logic [DW-1:0] d;
        int   edges, base;
        bit   seen;
        lat_max = 6; stall_pct = 30;
        for (int t = 0; t < 6; t++) begin
            r    = rand_row();
            d    = DW'($urandom_range(2048, 200));
            e    = model_row(r, d);
            base = iss_count;
            push_row(r, d);
            wait_valid(edges, seen);
            n_checks++;
            if (!seen || vec_out !== e) begin
                n_errors++;
                $display("FAIL rand_row%0d: seen=%0d got %h required %h", t, seen, vec_out, e);
            end
            n_checks++;
            if (iss_count - base != VL) begin
                n_errors++;
                $display("FAIL rand_issues%0d: got %0d required %0d", t, iss_count - base, VL);
            end
            release_row();
        end
    endtask

    task automatic test_done_hold();
        row_t ra, rb;
        vec_t v0, eb;
        logic [DW-1:0] db;
        int   edges;
        bit   seen;
        lat_max = 1; stall_pct = 0;
        ra = rand_row();
        rb = rand_row();
        db = DW'($urandom_range(1500, 300));
        eb = model_row(rb, db);
        push_row(ra, 16'h0200);
        wait_valid(edges, seen);
        v0 = vec_out;
        // next row offered while the current one is parked in DONE
        row_in    = rb;
        rowsum_in = db;
        vld_in    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #1;
            n_checks++;
            if (!seen || vec_out !== v0 || vld_out !== 1'b1 || rdy_out !== 1'b0) begin
                n_errors++;
                $display("FAIL hold%0d: vec=%h vld_out=%b rdy_out=%b required %h 1 0",
                         k, vec_out, vld_out, rdy_out, v0);
            end
        end
        rdy_in = 1'b1;
        @(posedge clock); #1;
        rdy_in = 1'b0;
        n_checks++;
        if (rdy_out !== 1'b1 || vld_out !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_release: rdy_out=%b vld_out=%b required 1 0", rdy_out, vld_out);
        end
        @(posedge clock); #1;
        vld_in = 1'b0;
        n_checks++;
        if (rdy_out !== 1'b0) begin
            n_errors++;
            $display("FAIL hold_accept: rdy_out=%b required 0", rdy_out);
        end
        wait_valid(edges, seen);
        n_checks++;
        if (!seen || vec_out !== eb) begin
            n_errors++;
            $display("FAIL hold_next: seen=%0d got %h required %h", seen, vec_out, eb);
        end
        release_row();
    endtask

    task automatic test_zero_rowsum();
        row_t r;
        vec_t e;
        int   edges, base, exp_iss;
        bit   seen;
        lat_max = 1; stall_pct = 0;
        r    = '0;
        r[0] = 16'h0080;   //  0.5
        r[1] = 16'hFF80;   // -0.5
`ifdef ROW_NORM_ZERO_BYPASS_EN
        e       = '0;
        exp_iss = 0;
`else
        for (int i = 0; i < VL; i++) e[i] = 8'h7F;
        e[1]    = 8'h80;
        exp_iss = VL;
`endif
        base = iss_count;
        push_row(r, 16'h0000);
        wait_valid(edges, seen);
        n_checks++;
        if (!seen || vec_out !== e) begin
            n_errors++;
            $display("FAIL zero_row: seen=%0d got %h required %h", seen, vec_out, e);
        end
        n_checks++;
        if (iss_count - base != exp_iss) begin
            n_errors++;
            $display("FAIL zero_issues: got %0d required %0d", iss_count - base, exp_iss);
        end
        release_row();
    endtask

    task automatic test_mid_reset();
        row_t r;
        vec_t e;
        logic [DW-1:0] d;
        int   edges, base, n;
        bit   seen;
        lat_max = 1; stall_pct = 0;
        base = iss_count;
        push_row(rand_row(), 16'h0300);
        n = 0;
        while (iss_count - base < 3 && n < 100) begin
            @(posedge clock); #1; n++;
        end
        n_checks++;
        if (iss_count - base < 3) begin
            n_errors++;
            $display("FAIL midrst_issue: got %0d issues required 3", iss_count - base);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_checks++;
        if (rdy_out !== 1'b1 || vld_out !== 1'b0 || div_vld_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_state: rdy_out=%b vld_out=%b div_vld_o=%b required 1 0 0",
                     rdy_out, vld_out, div_vld_o);
        end
        lat_max = 3; stall_pct = 20;
        r = rand_row();
        d = DW'($urandom_range(1200, 256));
        e = model_row(r, d);
        push_row(r, d);
        wait_valid(edges, seen);
        n_checks++;
        if (!seen || vec_out !== e) begin
            n_errors++;
            $display("FAIL midrst_next: seen=%0d got %h required %h", seen, vec_out, e);
        end
        release_row();
    endtask

    initial begin
        test_reset();
        test_unit_row();
        test_mixed_signs();
        test_random_latency();
        test_done_hold();
        test_zero_rowsum();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
